// File: rtl/controller_new_pkg.sv
// controller_new_pkg: shared types, op encodings and LFSR/MISR tap constants for the BIST wrapper
package controller_new_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_XOR = 1'b1;
  localparam int LFSR_TAP_HI = 8;
  localparam int LFSR_TAP_LO = 4;
  localparam logic [3:0] MISR_TAPS = 4'b1000;
  function automatic logic [3:0] alu(input logic [8:0] v);
    return (v[8] == OP_XOR) ? v[7:4] ^ v[3:0] : v[7:4] + v[3:0];
  endfunction
endpackage

// File: rtl/bist_misr.sv
// bist_misr: 4-bit multiple-input signature register with clear and enable
module bist_misr
  import controller_new_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] d,
  output logic [3:0] q,
  output logic [3:0] q_next
);
  logic [3:0] misr_q, misr_d;
  always_comb begin
    q_next = {misr_q[2:0], misr_q[3]} ^ d ^ ({4{misr_q[3]}} & MISR_TAPS);
    misr_d = clr ? '0 : en ? q_next : misr_q;
  end
  always_ff @(posedge clk) misr_q <= rst ? '0 : misr_d;
  assign q = misr_q;
endmodule

// File: rtl/controller_new.sv
// controller_new: BIST wrapper driving a 4-bit ALU from data_in or an LFSR and checking its MISR signature
module controller_new
  import controller_new_pkg::*;
#(
  parameter int         PATTERNS   = 16,
  parameter logic [8:0] LFSR_SEED  = 9'h001,
  parameter logic [3:0] GOLDEN_SIG = 4'h5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       BIST_mode,
  input  logic [8:0] data_in,
  input  logic       finish,
  output logic       fault_detected,
  output logic [3:0] misr_output,
  output logic [3:0] result_dut
);
  state_t state_q, state_d;
  logic [8:0] lfsr_q, lfsr_d, count_q, count_d;
  logic [3:0] result_q, cut, misr_next;
  logic fault_q, fault_d, clr, en, last;
  always_comb begin
    cut = alu(BIST_mode ? lfsr_q : data_in);
    clr = state_q == IDLE;
    en = state_q == RUN && BIST_mode;
    last = count_q == 9'(PATTERNS - 1) || finish;
    lfsr_d = clr ? LFSR_SEED : en ? {lfsr_q[7:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]} : lfsr_q;
    count_d = clr ? '0 : en ? count_q + 9'd1 : count_q;
    fault_d = (en && last) ? misr_next != GOLDEN_SIG : fault_q;
    state_d = state_q == IDLE ? (BIST_mode ? RUN : IDLE)
            : !BIST_mode ? IDLE
            : (state_q == RUN && last) ? DONE : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_q <= LFSR_SEED;
      count_q <= '0;
      result_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      count_q <= count_d;
      result_q <= cut;
      fault_q <= fault_d;
    end
  end
  bist_misr u_misr (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en(en),
    .d(cut),
    .q(misr_output),
    .q_next(misr_next)
  );
  assign result_dut = result_q;
  assign fault_detected = fault_q;
endmodule

// File: tb/tb_controller_new.sv
// tb_controller_new: randomized self-checking bench against an arithmetic BIST model
module tb_controller_new;
  function automatic int next_lfsr(input int l);
    return ((l << 1) & 511) | (((l >> 8) ^ (l >> 4)) & 1);
  endfunction
  function automatic int lfsr_at(input int n);
    int l = 1;
    for (int i = 0; i < n; i++) l = next_lfsr(l);
    return l;
  endfunction
  function automatic int cut_of(input int v);
    int a = (v >> 4) & 15;
    int b = v & 15;
    return ((v >> 8) & 1) != 0 ? a ^ b : (a + b) % 16;
  endfunction
  function automatic int sig_of(input int n);
    int l = 1;
    int m = 0;
    for (int i = 0; i < n; i++) begin
      int c = cut_of(l);
      m = (((m << 1) | (m >> 3)) & 15) ^ c ^ (m & 8);
      l = next_lfsr(l);
    end
    return m;
  endfunction
  localparam int GOOD = sig_of(16);
  localparam int BAD = GOOD ^ 1;
  logic clk = 0, rst, bist, fin;
  logic [8:0] din;
  logic fault_g, fault_b;
  logic [3:0] misr_g, misr_b, res_g, res_b;
  int total = 0, bad = 0;
  int exp_fg = 0, exp_fb = 0;
  always #5 clk = ~clk;
  controller_new #(.GOLDEN_SIG(4'(GOOD))) dut_g (
    .clk(clk), .rst(rst), .BIST_mode(bist), .data_in(din), .finish(fin),
    .fault_detected(fault_g), .misr_output(misr_g), .result_dut(res_g)
  );
  controller_new #(.GOLDEN_SIG(4'(BAD))) dut_b (
    .clk(clk), .rst(rst), .BIST_mode(bist), .data_in(din), .finish(fin),
    .fault_detected(fault_b), .misr_output(misr_b), .result_dut(res_b)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic bist_run(input int n_fin);
    int n = 16;
    bist = 1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      din = 9'($urandom);
      fin = k == n_fin;
      tick();
      fin = 0;
      chk("run_res", res_g, cut_of(lfsr_at(k - 1)));
      chk("run_misr", misr_g, sig_of(k));
      if (k == n_fin) begin
        n = k;
        break;
      end
    end
    exp_fg = sig_of(n) != GOOD;
    exp_fb = sig_of(n) != BAD;
    chk("done_fault_g", fault_g, exp_fg);
    chk("done_fault_b", fault_b, exp_fb);
    chk("done_misr_b", misr_b, sig_of(n));
    repeat (3) tick();
    chk("done_frozen", misr_g, sig_of(n));
    bist = 0;
    tick();
    tick();
    chk("idle_misr", misr_g, 0);
    chk("idle_fault_g", fault_g, exp_fg);
    chk("idle_fault_b", fault_b, exp_fb);
  endtask
  initial begin
    logic [8:0] dv [3];
    logic [3:0] de [3];
    dv = '{9'b0_0010_0101, 9'b1_1011_1111, 9'b0_1011_1011};
    de = '{4'b0111, 4'b0100, 4'b0110};
    rst = 1; bist = 0; fin = 0; din = 0;
    tick(); tick();
    chk("rst_res", res_g, 0);
    chk("rst_misr", misr_g, 0);
    chk("rst_fault", fault_b, 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      din = dv[i];
      tick();
      chk("norm_dir", res_g, de[i]);
    end
    for (int i = 0; i < 20; i++) begin
      din = 9'($urandom);
      fin = 1'($urandom);
      tick();
      chk("norm_rnd", res_g, cut_of(int'(din)));
      chk("norm_misr", misr_g, 0);
    end
    fin = 0;
    rst = 1;
    tick();
    rst = 0;
    bist_run(0);
    bist_run(0);
    bist_run(4);
    for (int i = 0; i < 4; i++) bist_run(int'($urandom_range(1, 16)));
    bist = 1;
    tick();
    repeat (3) tick();
    bist = 0;
    tick();
    tick();
    chk("abort_misr", misr_g, 0);
    chk("abort_fault_b", fault_b, exp_fb);
    bist_run(0);
    bist = 1;
    tick();
    repeat (5) tick();
    rst = 1;
    tick();
    chk("midrst_misr", misr_g, 0);
    chk("midrst_res", res_g, 0);
    chk("midrst_fault_g", fault_g, 0);
    chk("midrst_fault_b", fault_b, 0);
    rst = 0;
    bist = 0;
    tick();
    bist_run(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
